// File: rtl/timer_8_tick.sv
// Free-running 3-bit tick counter (0..7) with a one-cycle wrap strobe per 8-tick frame.
// Optional clock prescaler enabled by TIMER_8_TICK_PRESCALE_EN; default build ticks every cycle.
module timer_8_tick #(
   parameter int unsigned PRESCALE = 1
) (
   input  logic       clk,
   input  logic       rst,
   output logic [2:0] tick_out,
   output logic       wrap
);

   // A prescale of 0 is meaningless and behaves as 1
   localparam int unsigned PS_EFF = (PRESCALE == 0) ? 1 : PRESCALE;

   logic adv;

`ifdef TIMER_8_TICK_PRESCALE_EN
   localparam int unsigned PS_W = (PS_EFF <= 2) ? 1 : $clog2(PS_EFF);
   localparam logic [PS_W-1:0] PRE_LAST = PS_W'(PS_EFF - 1);

   logic [PS_W-1:0] pre_cnt;

   assign adv = (pre_cnt == PRE_LAST);

   // Prescale phase counter, cleared on every tick advance
   always_ff @(posedge clk) begin
      if (!rst) begin
         pre_cnt <= '0;
      end else if (adv) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + PS_W'(1);
      end
   end
`else
   // No prescaler: PS_EFF is always nonzero, so this is a constant 1
   assign adv = (PS_EFF != 0);
`endif

   // Tick index and wrap strobe; reset wins over a coincident 7->0 advance
   always_ff @(posedge clk) begin
      if (!rst) begin
         tick_out <= 3'd0;
         wrap     <= 1'b0;
      end else begin
         wrap <= adv && (tick_out == 3'd7);
         if (adv) begin
            tick_out <= tick_out + 3'd1;
         end
      end
   end

endmodule

// File: tb/tb_timer_8_tick.sv
// Randomized self-checking bench for timer_8_tick against a frame-arithmetic reference model.
`timescale 1ns/1ps
module tb_timer_8_tick;

   localparam int unsigned PS = 3;
`ifdef TIMER_8_TICK_PRESCALE_EN
   localparam int unsigned PERIOD = PS;
`else
   localparam int unsigned PERIOD = 1;
`endif

   logic       clk;
   logic       rst;
   logic [2:0] tick_out;
   logic       wrap;

   int checks;
   int failures;
   int unsigned run_edges;   // run edges since the last reset edge
   int unsigned wrap_seen;

   timer_8_tick #(.PRESCALE(PS)) dut (
      .clk      (clk),
      .rst      (rst),
      .tick_out (tick_out),
      .wrap     (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (run_edges=%0d)", tag, got, exp, run_edges);
      end
   endtask

   function automatic int unsigned exp_tick(input int unsigned n);
      return (n / PERIOD) % 8;
   endfunction

   function automatic int unsigned exp_wrap(input int unsigned n);
      return (n != 0 && (n % (8 * PERIOD)) == 0) ? 1 : 0;
   endfunction

   // Apply one rising edge with the given reset level, advance the model, compare outputs
   task automatic step(input logic r, input string tag);
      rst = r;
      @(posedge clk);
      #1;
      if (!r) run_edges = 0;
      else    run_edges++;
      check({tag, ".tick"}, 32'(tick_out), exp_tick(run_edges));
      check({tag, ".wrap"}, 32'(wrap), exp_wrap(run_edges));
      if (wrap) wrap_seen++;
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      run_edges = 0;
      wrap_seen = 0;
      rst       = 1'b0;
      @(negedge clk);

      // Reset hold
      for (int i = 0; i < 3; i++) step(1'b0, "reset_hold");
      check("reset_tick0", 32'(tick_out), 0);

      // Free run for 8 full frames
      wrap_seen = 0;
      for (int i = 0; i < 64 * PERIOD; i++) step(1'b1, "free_run");
      check("free_run_end", 32'(tick_out), 0);
      check("free_run_wraps", wrap_seen, 8);

      // Mid-count reset once the tick reaches 5
      for (int i = 0; i < 16 * PERIOD && exp_tick(run_edges) != 5; i++) step(1'b1, "to_five");
      check("reached_five", 32'(tick_out), 5);
      step(1'b0, "mid_reset");
      for (int i = 0; i < PERIOD; i++) step(1'b1, "after_mid");
      check("resume_one", 32'(tick_out), 1);

      // Reset on the edge that would carry 7 -> 0
      for (int i = 0; i < 16 * PERIOD && ((run_edges + 1) % (8 * PERIOD)) != 0; i++)
         step(1'b1, "to_wrap_edge");
      check("pre_wrap_seven", 32'(tick_out), 7);
      step(1'b0, "reset_on_wrap");
      check("reset_on_wrap_nowrap", 32'(wrap), 0);
      for (int i = 0; i < PERIOD; i++) step(1'b1, "after_wrap_reset");
      check("after_wrap_one", 32'(tick_out), 1);

      // Random reset pulses over long runs
      for (int i = 0; i < 800; i++) step(($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1, "random");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
